draw_scheduler: RTL and testbench

Command-queue controller that sequences the shape-drawing engines (fillscreen, circle, reuleaux) onto the single VGA framebuffer write port. Upstream logic pushes draw commands into a small FIFO. The scheduler pops one command at a time, presents its geometry on a shared configuration bus, and runs the selected engine through the start/done handshake. Only the active engine's vga_* outputs reach the framebuffer.

---
 rtl/draw_pkg.sv | 33 +++
 rtl/draw_scheduler_cmd_fifo.sv | 74 +++++++
 rtl/draw_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_draw_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared types for the draw scheduler: shape codes, queued command layout, FSM states.
// No logic, so no latency.
// No flow control of its own; consumers apply their own valid/ready.
package draw_pkg;

    typedef enum logic [1:0] {
        SH_FILL     = 2'd0,
        SH_CIRCLE   = 2'd1,
        SH_REULEAUX = 2'd2,
        SH_RSVD     = 2'd3
    } shape_e;

    // 2 + 3 + 8 + 7 + 8 = 28 bits per queued command
    typedef struct packed {
        shape_e      shape;
        logic [2:0]  colour;
        logic [7:0]  x;
        logic [6:0]  y;
        logic [7:0]  size;
    } draw_cmd_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RELEASE = 2'd2
    } sched_state_e;

    // Bit positions in eng_start/eng_done and slice index in the packed vga buses
    localparam int ENG_FILL   = 0;
    localparam int ENG_CIRCLE = 1;
    localparam int ENG_REU    = 2;

endpackage

// File: rtl/draw_scheduler_cmd_fifo.sv
// Command FIFO: registered storage, head is read directly from storage.
// A push is visible at the head no earlier than the edge after it is written (no bypass).
// Push ignored when full; pop ignored when empty; flush empties and wins over push/pop.
//
// Ports: clk, rst_n; push/push_dat write; pop advances head_dat;
//        flush clears; full, empty, count report occupancy.
module cmd_fifo
    import draw_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  draw_cmd_t     push_dat,
    input  logic          pop,
    input  logic          flush,
    output draw_cmd_t     head_dat,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    draw_cmd_t         mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic              push_ok, pop_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];

    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    // Pointers are exactly log2(DEPTH) wide, so natural overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{(CW-1){1'b0}}, push_ok} - {{(CW-1){1'b0}}, pop_ok};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/draw_scheduler.sv
// Draw scheduler: queues draw commands and runs one shape engine at a time onto the VGA port.
// Accept-to-start is 2 edges when idle; engine done to cmd_done is 1 edge; 3 edges between commands.
// cmd_ready drops when the FIFO is full or flush is high; engines are held via start/done.
//
// Ports: cmd_* push interface and flush; eng_start/eng_done handshake plus shared config bus
//        eng_colour/x/y/size; eng_vga_* packed engine outputs muxed onto vga_*;
//        busy, cmd_done, cmd_err status pulses and FIFO count.
module draw_scheduler
    import draw_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_shape,
    input  logic [2:0]    cmd_colour,
    input  logic [7:0]    cmd_x,
    input  logic [6:0]    cmd_y,
    input  logic [7:0]    cmd_size,
    input  logic          flush,
    output logic [2:0]    eng_start,
    input  logic [2:0]    eng_done,
    output logic [2:0]    eng_colour,
    output logic [7:0]    eng_x,
    output logic [6:0]    eng_y,
    output logic [7:0]    eng_size,
    input  logic [23:0]   eng_vga_x,
    input  logic [20:0]   eng_vga_y,
    input  logic [8:0]    eng_vga_colour,
    input  logic [2:0]    eng_vga_plot,
    output logic [7:0]    vga_x,
    output logic [6:0]    vga_y,
    output logic [2:0]    vga_colour,
    output logic          vga_plot,
    output logic          busy,
    output logic          cmd_done,
    output logic          cmd_err,
    output logic [CW-1:0] count
);

    draw_cmd_t    push_dat, head;
    logic         fifo_full, fifo_empty, pop;

    sched_state_e state_q, state_d;
    logic [2:0]   sel_q, sel_d;          // one-hot engine select, same encoding as eng_start
    logic [2:0]   start_q, start_d;
    logic [2:0]   colour_q, colour_d;
    logic [7:0]   x_q, x_d;
    logic [6:0]   y_q, y_d;
    logic [7:0]   size_q, size_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic         sel_done;

    assign cmd_ready = !fifo_full && !flush;
    assign push_dat  = '{shape: shape_e'(cmd_shape), colour: cmd_colour,
                         x: cmd_x, y: cmd_y, size: cmd_size};

    cmd_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (cmd_valid && cmd_ready),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (flush),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (count)
    );

    // Only the selected engine's done matters; the others are masked off.
    assign sel_done = |(eng_done & sel_q);

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        start_d  = start_q;
        colour_d = colour_q;
        x_d      = x_q;
        y_d      = y_q;
        size_d   = size_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // No pop on a flush edge: everything still in the FIFO is discarded.
                if (!fifo_empty && !flush) begin
                    pop = 1'b1;
                    if (head.shape == SH_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        sel_d    = 3'b001 << head.shape;
                        start_d  = 3'b001 << head.shape;
                        colour_d = head.colour;
                        x_d      = head.x;
                        y_d      = head.y;
                        size_d   = head.size;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                if (sel_done) begin
                    start_d = '0;
                    done_d  = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                // Wait for the engine to drop done so a stale level cannot finish the next command.
                if (!sel_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            start_q  <= '0;
            colour_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            size_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            start_q  <= start_d;
            colour_q <= colour_d;
            x_q      <= x_d;
            y_q      <= y_d;
            size_q   <= size_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign eng_start  = start_q;
    assign eng_colour = colour_q;
    assign eng_x      = x_q;
    assign eng_y      = y_q;
    assign eng_size   = size_q;
    assign cmd_done   = done_q;
    assign cmd_err    = err_q;
    assign busy       = (state_q != IDLE) || (count != '0);

    // Framebuffer port is driven only while an engine is running.
    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        if (state_q == RUN) begin
            unique case (sel_q)
                3'b001: begin
                    vga_x      = eng_vga_x[ENG_FILL*8 +: 8];
                    vga_y      = eng_vga_y[ENG_FILL*7 +: 7];
                    vga_colour = eng_vga_colour[ENG_FILL*3 +: 3];
                    vga_plot   = eng_vga_plot[ENG_FILL];
                end
                3'b010: begin
                    vga_x      = eng_vga_x[ENG_CIRCLE*8 +: 8];
                    vga_y      = eng_vga_y[ENG_CIRCLE*7 +: 7];
                    vga_colour = eng_vga_colour[ENG_CIRCLE*3 +: 3];
                    vga_plot   = eng_vga_plot[ENG_CIRCLE];
                end
                3'b100: begin
                    vga_x      = eng_vga_x[ENG_REU*8 +: 8];
                    vga_y      = eng_vga_y[ENG_REU*7 +: 7];
                    vga_colour = eng_vga_colour[ENG_REU*3 +: 3];
                    vga_plot   = eng_vga_plot[ENG_REU];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Testbench for draw_scheduler: directed commands, engine model, queue-based scoreboard.
// Expected starts/errors are queued at push time and consumed by a negedge monitor.
// Engine model holds done for a programmable time after start drops.
module tb_draw_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_shape;
    logic [2:0]  cmd_colour;
    logic [7:0]  cmd_x;
    logic [6:0]  cmd_y;
    logic [7:0]  cmd_size;
    logic        flush;
    logic [2:0]  eng_start;
    logic [2:0]  eng_done;
    logic [2:0]  eng_colour;
    logic [7:0]  eng_x;
    logic [6:0]  eng_y;
    logic [7:0]  eng_size;
    logic [23:0] eng_vga_x;
    logic [20:0] eng_vga_y;
    logic [8:0]  eng_vga_colour;
    logic [2:0]  eng_vga_plot;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        busy;
    logic        cmd_done;
    logic        cmd_err;
    logic [2:0]  count;

    logic [2:0]  model_done = 3'b000;
    logic [2:0]  stray = 3'b000;
    int          run_len = 10;
    int          hold_len = 1;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        bit         is_err;
        logic [2:0] start;
        logic [2:0] colour;
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] size;
    } exp_t;

    exp_t exp_q[$];

    assign eng_done       = model_done | stray;
    assign eng_vga_x      = {8'hC3, 8'hB2, 8'hA1};
    assign eng_vga_y      = {7'h43, 7'h32, 7'h21};
    assign eng_vga_colour = {3'd6, 3'd5, 3'd4};
    assign eng_vga_plot   = 3'b111;

    always #5 clk = ~clk;

    draw_scheduler #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_shape(cmd_shape),
        .cmd_colour(cmd_colour), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_size(cmd_size),
        .flush(flush), .eng_start(eng_start), .eng_done(eng_done),
        .eng_colour(eng_colour), .eng_x(eng_x), .eng_y(eng_y), .eng_size(eng_size),
        .eng_vga_x(eng_vga_x), .eng_vga_y(eng_vga_y), .eng_vga_colour(eng_vga_colour),
        .eng_vga_plot(eng_vga_plot), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy),
        .cmd_done(cmd_done), .cmd_err(cmd_err), .count(count)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Engine model: done after run_len cycles, held hold_len cycles after start drops.
    initial begin
        logic [2:0] s;
        forever begin
            @(negedge clk);
            if (eng_start != 3'b000 && rst_n) begin
                s = eng_start;
                for (int c = 0; c < run_len && rst_n; c++) @(negedge clk);
                if (rst_n) begin
                    model_done = s;
                    while (eng_start != 3'b000 && rst_n) @(negedge clk);
                    for (int c = 0; c < hold_len && rst_n; c++) @(negedge clk);
                end
                model_done = 3'b000;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        exp_t       cur;
        exp_t       e;
        logic [2:0] prev_start;
        logic       prev_done;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
        cur = '{default: '0};
        prev_start = 3'b000;
        prev_done  = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_start != 3'b000 && prev_start == 3'b000) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_start", {29'd0, eng_start}, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check("start_kind", {31'd0, cur.is_err}, 32'd0);
                    check("start_vec", {29'd0, eng_start}, {29'd0, cur.start});
                    check("start_after_done_drop", {29'd0, model_done}, 32'd0);
                end
            end
            if (cmd_err) begin
                err_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_err", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("err_kind", {31'd0, e.is_err}, 32'd1);
                    check("err_no_start", {29'd0, eng_start}, 32'd0);
                end
            end
            if (eng_start != 3'b000) begin
                check("cfg_bus", {eng_colour, eng_x, eng_y, eng_size},
                      {cur.colour, cur.x, cur.y, cur.size});
                ex = (cur.start == 3'b001) ? 8'hA1 : (cur.start == 3'b010) ? 8'hB2 : 8'hC3;
                ey = (cur.start == 3'b001) ? 7'h21 : (cur.start == 3'b010) ? 7'h32 : 7'h43;
                ec = (cur.start == 3'b001) ? 3'd4  : (cur.start == 3'b010) ? 3'd5  : 3'd6;
                check("vga_mux_run", {vga_plot, vga_x, vga_y, vga_colour}, {1'b1, ex, ey, ec});
            end else begin
                check("vga_idle_zero", {vga_plot, vga_x, vga_y, vga_colour}, 32'd0);
            end
            if (cmd_done) begin
                done_cnt++;
                check("done_pulse_width", {31'd0, prev_done}, 32'd0);
            end
            prev_start = eng_start;
            prev_done  = cmd_done;
        end
    end

    task automatic push_cmd(input logic [1:0] sh, input logic [2:0] c, input logic [7:0] x,
                            input logic [6:0] y, input logic [7:0] s);
        exp_t e;
        int   b;
        @(negedge clk);
        b = 0;
        while (!cmd_ready && b < 500) begin
            @(negedge clk);
            b++;
        end
        if (!cmd_ready) begin
            check("push_ready_timeout", 32'd0, 32'd1);
            return;
        end
        cmd_shape = sh; cmd_colour = c; cmd_x = x; cmd_y = y; cmd_size = s;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        e.is_err = (sh == 2'd3);
        e.start  = (sh == 2'd3) ? 3'b000 : (3'b001 << sh);
        e.colour = c; e.x = x; e.y = y; e.size = s;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int budget);
        int b;
        b = 0;
        @(negedge clk);
        while (busy && b < budget) begin
            @(negedge clk);
            b++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int base;
        int ebase;
        int b;
        rst_n = 1'b0; cmd_valid = 1'b0; flush = 1'b0;
        cmd_shape = '0; cmd_colour = '0; cmd_x = '0; cmd_y = '0; cmd_size = '0;
        #1;
        check("rst_outputs", {eng_start, vga_plot, cmd_done, cmd_err, busy, count},
              {3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0});
        check("rst_cfg", {eng_colour, eng_x, eng_y, eng_size}, 32'd0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: single circle
        run_len = 50; hold_len = 1;
        push_cmd(2'd1, 3'b010, 8'd80, 7'd60, 8'd20);
        check("t1_no_bypass", {29'd0, eng_start}, 32'd0);
        check("t1_count1", {29'd0, count}, 32'd1);
        @(posedge clk); #1;
        check("t1_start", {29'd0, eng_start}, 32'b010);
        check("t1_cfg", {eng_x, eng_y, eng_size}, {8'd80, 7'd60, 8'd20});
        check("t1_busy", {31'd0, busy}, 32'd1);
        wait_idle(300);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_exp_empty", exp_q.size(), 0);

        // 2: fill the queue behind a running command
        run_len = 20;
        base = done_cnt;
        push_cmd(2'd1, 3'd1, 8'd10, 7'd5, 8'd3);
        @(posedge clk); #1;
        push_cmd(2'd0, 3'd4, 8'd0, 7'd0, 8'd0);
        push_cmd(2'd2, 3'd5, 8'd100, 7'd50, 8'd30);
        push_cmd(2'd1, 3'd6, 8'd20, 7'd21, 8'd22);
        push_cmd(2'd1, 3'd7, 8'd33, 7'd44, 8'd55);
        check("t2_count_full", {29'd0, count}, 32'd4);
        check("t2_ready_low", {31'd0, cmd_ready}, 32'd0);
        wait_idle(1000);
        check("t2_done_cnt", done_cnt, base + 5);
        check("t2_exp_empty", exp_q.size(), 0);

        // 3: reserved shape then circle
        run_len = 8;
        base = done_cnt; ebase = err_cnt;
        push_cmd(2'd3, 3'd2, 8'd1, 7'd2, 8'd3);
        push_cmd(2'd1, 3'd3, 8'd40, 7'd30, 8'd10);
        wait_idle(300);
        check("t3_err_cnt", err_cnt, ebase + 1);
        check("t3_done_cnt", done_cnt, base + 1);
        check("t3_exp_empty", exp_q.size(), 0);

        // 4: stray done from a non-selected engine, long done hold
        run_len = 10; hold_len = 5;
        base = done_cnt;
        push_cmd(2'd1, 3'd1, 8'd7, 7'd8, 8'd9);
        repeat (3) @(negedge clk);
        stray = 3'b100;
        repeat (3) @(negedge clk);
        stray = 3'b000;
        check("t4_stray_no_done", done_cnt, base);
        check("t4_still_running", {29'd0, eng_start}, 32'b010);
        b = 0;
        while (!cmd_done && b < 100) begin
            @(negedge clk);
            b++;
        end
        check("t4_done_seen", {31'd0, cmd_done}, 32'd1);
        repeat (5) @(negedge clk);
        check("t4_release_busy", {busy, eng_start}, {1'b1, 3'b000});
        @(negedge clk);
        check("t4_release_exit", {31'd0, busy}, 32'd0);
        hold_len = 1;
        wait_idle(100);
        check("t4_done_cnt", done_cnt, base + 1);

        // 5: flush with 3 queued, 1 in flight, simultaneous push
        run_len = 40;
        base = done_cnt;
        push_cmd(2'd1, 3'd2, 8'd11, 7'd12, 8'd13);
        @(posedge clk); #1;
        push_cmd(2'd0, 3'd1, 8'd0, 7'd0, 8'd0);
        push_cmd(2'd2, 3'd2, 8'd5, 7'd6, 8'd7);
        push_cmd(2'd1, 3'd3, 8'd8, 7'd9, 8'd10);
        check("t5_count3", {29'd0, count}, 32'd3);
        @(negedge clk);
        flush = 1'b1;
        cmd_valid = 1'b1; cmd_shape = 2'd0; cmd_colour = 3'd7;
        #1;
        check("t5_ready_flush", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; cmd_valid = 1'b0;
        exp_q.delete();
        check("t5_count0", {29'd0, count}, 32'd0);
        check("t5_inflight", {29'd0, eng_start}, 32'b010);
        wait_idle(300);
        repeat (5) @(negedge clk);
        check("t5_done_cnt", done_cnt, base + 1);

        // 6: async reset mid-run
        run_len = 40;
        push_cmd(2'd1, 3'd5, 8'd50, 7'd40, 8'd30);
        push_cmd(2'd2, 3'd6, 8'd60, 7'd41, 8'd31);
        check("t6_pushpop_count", {29'd0, count}, 32'd1);
        check("t6_running", {29'd0, eng_start}, 32'b010);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_async_rst", {eng_start, vga_plot, busy, count}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = done_cnt;
        run_len = 5;
        push_cmd(2'd0, 3'd3, 8'd0, 7'd0, 8'd0);
        @(posedge clk); #1;
        check("t6_restart", {29'd0, eng_start}, 32'b001);
        wait_idle(200);
        check("t6_done_cnt", done_cnt, base + 1);
        check("t6_exp_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
